// File: rtl/IKA9958_mnemonics.sv
// Shared constants for the ika9958 background fetch path: PLA slot numbers,
// mode encodings, column limits, fetch FSM states and the pixel colour pick.
package IKA9958_mnemonics;

   localparam logic MODE_T1 = 1'b1;
   localparam logic MODE_G1 = 1'b0;

   localparam logic [3:0] SLOT_NAME = 4'd1;
   localparam logic [3:0] SLOT_PAT  = 4'd4;
   localparam logic [3:0] SLOT_COL  = 4'd7;

   localparam logic [5:0] COLS_T1 = 6'd40;
   localparam logic [5:0] COLS_G1 = 6'd32;

   localparam logic [3:0] PX_T1 = 4'd6;
   localparam logic [3:0] PX_G1 = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NAME,
      ST_PAT,
      ST_COL,
      ST_WAIT
   } slot_state_t;

   function automatic logic [3:0] pix_select(input logic       bit_on,
                                             input logic       txt,
                                             input logic [7:0] color,
                                             input logic [3:0] fg,
                                             input logic [3:0] bg);
      logic [3:0] on_code;
      logic [3:0] off_code;
      on_code  = (txt == MODE_T1) ? fg : color[7:4];
      off_code = (txt == MODE_T1) ? bg : color[3:0];
      return bit_on ? on_code : off_code;
   endfunction

endpackage

// File: rtl/ika9958_pixel_shifter.sv
// Tile pixel serializer: loads pattern/colour at end of tile and emits one
// 4-bit pixel code per two enabled cycles, MSB first (6 px T1, 8 px G1).
module ika9958_pixel_shifter
   import IKA9958_mnemonics::*;
(
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic       cen,
   input  logic       load,
   input  logic       txt_in,
   input  logic       act_in,
   input  logic [7:0] pat_in,
   input  logic [7:0] color_in,
   input  logic [3:0] txt_fg,
   input  logic [3:0] txt_bg,
   output logic [3:0] pix_code,
   output logic       pix_valid
);

   logic [7:0] sr_q;
   logic [7:0] color_q;
   logic [3:0] cnt_q;
   logic       half_q;
   logic       txt_q;
   logic       act_q;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sr_q    <= 8'h00;
         color_q <= 8'h00;
         cnt_q   <= 4'd0;
         half_q  <= 1'b0;
         txt_q   <= MODE_G1;
         act_q   <= 1'b0;
      end else if (cen) begin
         if (load) begin
            sr_q    <= pat_in;
            color_q <= color_in;
            txt_q   <= txt_in;
            act_q   <= act_in;
            cnt_q   <= (txt_in == MODE_T1) ? PX_T1 : PX_G1;
            half_q  <= 1'b0;
         end else if (cnt_q != 4'd0) begin
            // each pixel is held for two enabled cycles
            half_q <= ~half_q;
            if (half_q) begin
               sr_q  <= {sr_q[6:0], 1'b0};
               cnt_q <= cnt_q - 4'd1;
            end
         end
      end
   end

   assign pix_code  = (cnt_q != 4'd0) ? pix_select(sr_q[7], txt_q, color_q, txt_fg, txt_bg) : 4'd0;
   assign pix_valid = (cnt_q != 4'd0) && act_q;

endmodule

// File: rtl/ika9958_tile_fetch.sv
// Per-tile VRAM fetch sequencer for T1/G1 backgrounds; optional sticky miss
// flag and debug miss counter under IKA9958_FETCH_MISS_EN.
//
// state   | meaning
// IDLE    | no fetch outstanding, watching for a slot decode
// NAME    | first cycle of name-table read request
// PAT     | first cycle of pattern-generator read request
// COL     | first cycle of colour-table read request (G1 only)
// WAIT    | request still held, waiting for ack (kind kept in kind_q)
module ika9958_tile_fetch
   import IKA9958_mnemonics::*;
(
   input  logic        phiA,
   input  logic        RST_async_n,
   input  logic        phiL_NCEN,
   input  logic [8:0]  comcntr,
   input  logic        pla_eot,
   input  logic        pla_line0,
   input  logic        txtmode,
   input  logic [7:0]  vline,
   input  logic [6:0]  nt_base,
   input  logic [5:0]  pg_base,
   input  logic [10:0] ct_base,
   input  logic [3:0]  txt_fg,
   input  logic [3:0]  txt_bg,
   output logic        vram_req,
   output logic [16:0] vram_addr,
   input  logic        vram_ack,
   input  logic [7:0]  vram_data,
   output logic [3:0]  pix_code,
   output logic        pix_valid,
   output logic        fetch_miss
);

   slot_state_t state_q, state_next, kind_q, cur_kind;
   logic [5:0]  col_q;
   logic [7:0]  name_q, pat_q, color_q;
   logic [16:0] addr_q, issue_addr;
   logic [9:0]  t1_off;
   logic        col_active, issue, capture, abort;
   logic        unused_hi;

   assign unused_hi  = ^comcntr[8:4];
   assign col_active = col_q < ((txtmode == MODE_T1) ? COLS_T1 : COLS_G1);
   // T1 rows are 40 chars; 10-bit offset intentionally wraps
   assign t1_off     = {5'd0, vline[7:3]} * 10'd40 + {4'd0, col_q};

   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) state_q <= ST_IDLE;
      else              state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      if (phiL_NCEN) begin
         case (state_q)
            ST_IDLE: begin
               if (col_active) begin
                  if (comcntr[3:0] == SLOT_NAME)
                     state_next = ST_NAME;
                  else if (comcntr[3:0] == SLOT_PAT)
                     state_next = ST_PAT;
                  else if (comcntr[3:0] == SLOT_COL && txtmode == MODE_G1)
                     state_next = ST_COL;
               end
            end
            ST_NAME, ST_PAT, ST_COL:
               state_next = (pla_eot || vram_ack) ? ST_IDLE : ST_WAIT;
            ST_WAIT:
               if (pla_eot || vram_ack) state_next = ST_IDLE;
            default:
               state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      vram_req  = (state_q != ST_IDLE);
      vram_addr = addr_q;
      cur_kind  = (state_q == ST_WAIT) ? kind_q : state_q;
      issue     = (state_q == ST_IDLE) && (state_next != ST_IDLE);
      // end of tile drops an outstanding fetch even if ack arrives with it
      capture   = phiL_NCEN && vram_req && vram_ack && !pla_eot;
      abort     = phiL_NCEN && vram_req && pla_eot;
   end

   always_comb begin
      issue_addr = addr_q;
      case (state_next)
         ST_NAME: issue_addr = (txtmode == MODE_T1) ? {nt_base, t1_off}
                                                    : {nt_base, vline[7:3], col_q[4:0]};
         ST_PAT:  issue_addr = {pg_base, name_q, vline[2:0]};
         ST_COL:  issue_addr = {ct_base, 1'b0, name_q[7:3]};
         default: issue_addr = addr_q;
      endcase
   end

   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) begin
         col_q   <= 6'd0;
         addr_q  <= 17'd0;
         kind_q  <= ST_IDLE;
         name_q  <= 8'h00;
         pat_q   <= 8'h00;
         color_q <= 8'h00;
      end else if (phiL_NCEN) begin
         if (pla_line0)
            col_q <= 6'd0;
         else if (pla_eot && col_q != 6'd63)
            col_q <= col_q + 6'd1;

         if (issue) begin
            addr_q <= issue_addr;
            kind_q <= state_next;
         end

         if (pla_eot) begin
            name_q  <= 8'h00;
            pat_q   <= 8'h00;
            color_q <= 8'h00;
         end else if (capture) begin
            case (cur_kind)
               ST_NAME: name_q  <= vram_data;
               ST_PAT:  pat_q   <= vram_data;
               ST_COL:  color_q <= vram_data;
               default: ;
            endcase
         end
      end
   end

   ika9958_pixel_shifter u_shifter (
      .clk_sys   (phiA),
      .rst_b     (RST_async_n),
      .cen       (phiL_NCEN),
      .load      (pla_eot),
      .txt_in    (txtmode),
      .act_in    (col_active),
      .pat_in    (pat_q),
      .color_in  (color_q),
      .txt_fg    (txt_fg),
      .txt_bg    (txt_bg),
      .pix_code  (pix_code),
      .pix_valid (pix_valid)
   );

`ifdef IKA9958_FETCH_MISS_EN
   logic       miss_q;
   logic [7:0] dbg_miss_cnt;

   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) begin
         miss_q       <= 1'b0;
         dbg_miss_cnt <= 8'd0;
      end else if (abort) begin
         miss_q <= 1'b1;
         if (dbg_miss_cnt != 8'hFF) dbg_miss_cnt <= dbg_miss_cnt + 8'd1;
      end
   end

   assign fetch_miss = miss_q;
`else
   assign fetch_miss = 1'b0;
`endif

endmodule
